// File: rtl/vectorized_result_collector.sv
// Re-aligns skewed per-lane PE results into full-width AXI4-Stream phits.
// Each lane has its own FWFT FIFO; a phit is offered once every lane holds an element.
module vectorized_result_collector #(
  parameter int SIMD_degree  = 16,
  parameter int dwidth_float = 32,
  parameter int phit_size    = SIMD_degree * dwidth_float,
  parameter int fifo_depth   = 32,
  parameter int af_thresh    = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [phit_size-1:0]   i_PE_data,
  input  logic [SIMD_degree-1:0] i_tvalid_PE,
  input  logic [SIMD_degree-1:0] i_tlast_PE,
  output logic [phit_size-1:0]   o_axis_tdata,
  output logic                   o_axis_tvalid,
  input  logic                   i_axis_tready,
  output logic                   o_axis_tlast,
  output logic                   o_almost_full,
  output logic                   o_err_overflow,
  output logic                   o_err_tlast_mismatch,
  output logic [31:0]            o_beat_count,
  output logic [31:0]            o_pkt_count
);

  localparam int AW = $clog2(fifo_depth);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(fifo_depth);
  localparam logic [OW-1:0] AF_C    = OW'(af_thresh);

  // Each entry is {tlast, data}
  logic [dwidth_float:0]  mem     [SIMD_degree][fifo_depth];
  logic [AW-1:0]          wr_ptr  [SIMD_degree];
  logic [AW-1:0]          rd_ptr  [SIMD_degree];
  logic [OW-1:0]          occ     [SIMD_degree];
  logic [OW-1:0]          occ_nxt [SIMD_degree];
  logic [SIMD_degree-1:0] nonempty;
  logic [SIMD_degree-1:0] head_last;
  logic [SIMD_degree-1:0] push_ok;
  logic                   pop;
  logic                   af_nxt;
  logic                   mismatch;
  logic                   drop;

  always_comb begin
    nonempty     = '0;
    head_last    = '0;
    o_axis_tdata = '0;
    for (int i = 0; i < SIMD_degree; i++) begin
      nonempty[i] = (occ[i] != '0);
      head_last[i] = mem[i][rd_ptr[i]][dwidth_float];
      o_axis_tdata[i*dwidth_float +: dwidth_float] = mem[i][rd_ptr[i]][dwidth_float-1:0];
    end
  end

  assign o_axis_tvalid = &nonempty;
  assign o_axis_tlast  = head_last[0];
  assign pop           = o_axis_tvalid && i_axis_tready;
  assign mismatch      = pop && (head_last != {SIMD_degree{head_last[0]}});
  assign drop          = |(i_tvalid_PE & ~push_ok);

  // A full lane still accepts a push when the common pop frees a slot the same cycle
  always_comb begin
    push_ok = '0;
    af_nxt  = 1'b0;
    for (int i = 0; i < SIMD_degree; i++) begin
      push_ok[i] = i_tvalid_PE[i] && ((occ[i] != DEPTH_C) || pop);
      occ_nxt[i] = occ[i];
      if (push_ok[i] && !pop)
        occ_nxt[i] = occ[i] + 1'b1;
      else if (!push_ok[i] && pop)
        occ_nxt[i] = occ[i] - 1'b1;
      if (occ_nxt[i] >= AF_C)
        af_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SIMD_degree; i++) begin
        if (push_ok[i])
          mem[i][wr_ptr[i]] <= {i_tlast_PE[i], i_PE_data[i*dwidth_float +: dwidth_float]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIMD_degree; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        occ[i]    <= '0;
      end
      o_almost_full        <= 1'b0;
      o_err_overflow       <= 1'b0;
      o_err_tlast_mismatch <= 1'b0;
      o_beat_count         <= '0;
      o_pkt_count          <= '0;
    end else begin
      for (int i = 0; i < SIMD_degree; i++) begin
        if (push_ok[i])
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop)
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        occ[i] <= occ_nxt[i];
      end
      o_almost_full <= af_nxt;
      if (drop)
        o_err_overflow <= 1'b1;
      if (mismatch)
        o_err_tlast_mismatch <= 1'b1;
      if (pop) begin
        o_beat_count <= o_beat_count + 32'd1;
        if (head_last[0])
          o_pkt_count <= o_pkt_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_vectorized_result_collector.sv
// Bench for vectorized_result_collector: table of cycle vectors plus multi-cycle sequences,
// with every offered phit checked against a queue of expected {tlast, data}.
module tb_vectorized_result_collector;

  localparam int N = 16;
  localparam int W = 32;
  localparam int P = N * W;

  logic         clk = 1'b0;
  logic         rst;
  logic [P-1:0] i_PE_data;
  logic [N-1:0] i_tvalid_PE;
  logic [N-1:0] i_tlast_PE;
  logic [P-1:0] o_axis_tdata;
  logic         o_axis_tvalid;
  logic         i_axis_tready;
  logic         o_axis_tlast;
  logic         o_almost_full;
  logic         o_err_overflow;
  logic         o_err_tlast_mismatch;
  logic [31:0]  o_beat_count;
  logic [31:0]  o_pkt_count;

  vectorized_result_collector dut (
    .clk(clk), .rst(rst),
    .i_PE_data(i_PE_data), .i_tvalid_PE(i_tvalid_PE), .i_tlast_PE(i_tlast_PE),
    .o_axis_tdata(o_axis_tdata), .o_axis_tvalid(o_axis_tvalid),
    .i_axis_tready(i_axis_tready), .o_axis_tlast(o_axis_tlast),
    .o_almost_full(o_almost_full), .o_err_overflow(o_err_overflow),
    .o_err_tlast_mismatch(o_err_tlast_mismatch),
    .o_beat_count(o_beat_count), .o_pkt_count(o_pkt_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [P:0] sb[$];

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] l;
    int           base;
    logic         rdy;
    logic         add;
    logic         exp_v;
    logic [31:0]  exp_beat;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [P-1:0] mk(input int base);
    logic [P-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(base * 256 + i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic [P-1:0] d,
                       input logic r);
    i_tvalid_PE   = v;
    i_tlast_PE    = l;
    i_PE_data     = d;
    i_axis_tready = r;
  endtask

  // Offered phit must match the queue head every cycle it is valid, stalled or not
  always @(negedge clk) begin
    if (!rst && o_axis_tvalid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL phit_unexpected: tvalid=1 tlast=%0b with no expected phit", o_axis_tlast);
      end else begin
        if ({o_axis_tlast, o_axis_tdata} !== sb[0]) begin
          errors++;
          $display("FAIL phit: got last=%0b data=%h expected last=%0b data=%h",
                   o_axis_tlast, o_axis_tdata, sb[0][P], sb[0][P-1:0]);
        end
        if (i_axis_tready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //          v         l     base rdy add exp_v beat
    tbl[0] = '{16'hFFFF, 16'h0, 0, 1'b1, 1'b1, 1'b1, 32'd0};
    tbl[1] = '{16'h0000, 16'h0, 0, 1'b1, 1'b0, 1'b0, 32'd1};
    tbl[2] = '{16'h00FF, 16'h0, 2, 1'b1, 1'b1, 1'b0, 32'd1};
    tbl[3] = '{16'h0000, 16'h0, 0, 1'b1, 1'b0, 1'b0, 32'd1};
    tbl[4] = '{16'h0000, 16'h0, 0, 1'b1, 1'b0, 1'b0, 32'd1};
    tbl[5] = '{16'hFF00, 16'h0, 2, 1'b1, 1'b0, 1'b1, 32'd1};
    tbl[6] = '{16'h0000, 16'h0, 0, 1'b1, 1'b0, 1'b0, 32'd2};

    rst = 1'b1;
    drive('0, '0, '0, 1'b0);
    tick();
    tick();
    chk("rst_tvalid", o_axis_tvalid, 0);
    chk("rst_af", o_almost_full, 0);
    chk("rst_ovf", o_err_overflow, 0);
    chk("rst_mm", o_err_tlast_mismatch, 0);
    chk("rst_beat", o_beat_count, 0);
    chk("rst_pkt", o_pkt_count, 0);
    rst = 1'b0;

    // Single full push, then lanes 0-7 and 8-15 skewed by three cycles
    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].l, mk(tbl[k].base), tbl[k].rdy);
      if (tbl[k].add) sb.push_back({1'b0, mk(tbl[k].base)});
      tick();
      chk($sformatf("tbl%0d_tvalid", k), o_axis_tvalid, tbl[k].exp_v);
      chk($sformatf("tbl%0d_beat", k), o_beat_count, tbl[k].exp_beat);
    end

    // Fill to full while stalled, push+pop on full, then a dropped push
    for (int k = 0; k < 32; k++) begin
      drive('1, '0, mk(100 + k), 1'b0);
      sb.push_back({1'b0, mk(100 + k)});
      tick();
      if (k == 22) chk("af_at_23", o_almost_full, 0);
      if (k == 23) chk("af_at_24", o_almost_full, 1);
      if (k == 31) chk("ovf_at_32", o_err_overflow, 0);
    end
    drive('1, '0, mk(132), 1'b1);
    sb.push_back({1'b0, mk(132)});
    tick();
    chk("ovf_push_pop_full", o_err_overflow, 0);
    drive('1, '0, mk(133), 1'b0);
    tick();
    chk("ovf_drop", o_err_overflow, 1);
    drive('0, '0, '0, 1'b1);
    n = 0;
    while (o_axis_tvalid && n < 64) begin
      tick();
      n++;
    end
    chk("drain_cycles", n, 32);
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_beat", o_beat_count, 35);
    chk("drain_af", o_almost_full, 0);

    // 4-beat packet with tready toggling
    for (int j = 0; j < 4; j++) begin
      drive('1, (j == 3) ? '1 : '0, mk(200 + j), j[0]);
      sb.push_back({(j == 3), mk(200 + j)});
      tick();
    end
    i_tvalid_PE = '0;
    n = 0;
    while (o_axis_tvalid && n < 20) begin
      i_axis_tready = ~i_axis_tready;
      tick();
      n++;
    end
    chk("pkt_drain_in_time", (n < 20), 1);
    chk("pkt_sb_empty", sb.size(), 0);
    chk("pkt_beat", o_beat_count, 39);
    chk("pkt_count", o_pkt_count, 1);

    // Lane 5 alone marks tlast
    drive('1, 16'h0020, mk(400), 1'b1);
    sb.push_back({1'b0, mk(400)});
    tick();
    chk("mm_before_pop", o_err_tlast_mismatch, 0);
    chk("mm_tlast", o_axis_tlast, 0);
    drive('0, '0, '0, 1'b1);
    tick();
    chk("mm_after_pop", o_err_tlast_mismatch, 1);
    chk("mm_pkt", o_pkt_count, 1);
    chk("mm_beat", o_beat_count, 40);

    // Reset with data buffered and a push in the reset cycle
    for (int k = 0; k < 10; k++) begin
      drive('1, '0, mk(500 + k), 1'b0);
      sb.push_back({1'b0, mk(500 + k)});
      tick();
    end
    chk("prerst_tvalid", o_axis_tvalid, 1);
    rst = 1'b1;
    drive('1, '1, mk(600), 1'b1);
    sb.delete();
    tick();
    rst = 1'b0;
    drive('0, '0, '0, 1'b1);
    chk("rst2_tvalid", o_axis_tvalid, 0);
    chk("rst2_beat", o_beat_count, 0);
    chk("rst2_pkt", o_pkt_count, 0);
    chk("rst2_ovf", o_err_overflow, 0);
    chk("rst2_mm", o_err_tlast_mismatch, 0);
    chk("rst2_af", o_almost_full, 0);
    tick();
    chk("rst2_no_phit", o_axis_tvalid, 0);
    drive('1, '0, mk(700), 1'b1);
    sb.push_back({1'b0, mk(700)});
    tick();
    chk("fresh_tvalid", o_axis_tvalid, 1);
    drive('0, '0, '0, 1'b1);
    tick();
    chk("fresh_beat", o_beat_count, 1);
    chk("fresh_done", o_axis_tvalid, 0);
    chk("fresh_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vectorized_result_collector.md
Name: vectorized_result_collector

Overview:
- Receive end of the vectorized PE output stream: accepts up to SIMD_degree independent per-lane results (data/tvalid/tlast, no backpressure) and re-aligns them into full-width phits.
- Drives a standard AXI4-Stream master (tdata/tvalid/tready/tlast) toward the kernel output/network interface.
- Absorbs lane skew and downstream stalls in per-lane FIFOs.
- Exports almost-full so the upstream PE scheduler can throttle.

Parameters:
- SIMD_degree, 16, number of lanes
- dwidth_float, 32, bits per lane element
- phit_size, 512, SIMD_degree*dwidth_float; output tdata width
- fifo_depth, 32, entries per lane FIFO; power of two, >= 4
- af_thresh, 24, lane occupancy at or above which almost-full asserts

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_PE_data  in  phit_size  lane i occupies bits [(i+1)*dwidth_float-1 : i*dwidth_float]
- i_tvalid_PE  in  SIMD_degree  per-lane valid; one element pushed per asserted bit per cycle
- i_tlast_PE  in  SIMD_degree  per-lane last-of-packet marker
- o_axis_tdata  out  phit_size  aligned output phit (lane i in same bit slice as input)
- o_axis_tvalid  out  1  AXI-Stream valid
- i_axis_tready  in  1  AXI-Stream ready
- o_axis_tlast  out  1  AXI-Stream last
- o_almost_full  out  1  any lane occupancy >= af_thresh
- o_err_overflow  out  1  sticky; a push was dropped on a full lane
- o_err_tlast_mismatch  out  1  sticky; lane heads disagreed on tlast at a pop
- o_beat_count  out  32  count of completed output handshakes, wraps at 2^32
- o_pkt_count  out  32  count of completed handshakes with tlast=1, wraps

Behaviour:
- Reset (rst=1 at a clk edge), from the same edge:
  - all read/write pointers and occupancies cleared; o_axis_tvalid=0
  - o_almost_full=0, both error flags 0, both counters 0
  - pushes in the reset cycle are discarded
  - reset mid-packet discards all buffered data; no partial phit is emitted afterwards
- Per-lane FIFO:
  - stores {tlast, data}, fifo_depth entries
  - push when i_tvalid_PE[i]=1; pop is common to all lanes
  - lanes are pushed independently; skew between lanes is allowed
- Output, first-word-fall-through:
  - o_axis_tvalid = every lane non-empty
  - o_axis_tdata = concatenation of lane heads
  - registered state only, so an element pushed at edge N is visible at the output after edge N (latency 1 cycle when all other lanes are already non-empty)
- Handshake:
  - pop on all lanes when o_axis_tvalid && i_axis_tready
  - once asserted, o_axis_tvalid stays high and tdata/tlast stay stable until the handshake; pushes never alter heads
- tlast:
  - o_axis_tlast = lane 0 head tlast
  - at a pop, if any lane head tlast differs from lane 0, set o_err_tlast_mismatch; the pop still proceeds
- Full lane:
  - push to a full lane with no pop that cycle is dropped; sets o_err_overflow; other lanes unaffected
  - push and pop in the same cycle on a full lane is accepted; occupancy is unchanged
- Empty lane: no pop occurs; tvalid stays low.
- Pointers: wrap modulo fifo_depth; occupancy counters are log2(fifo_depth)+1 bits.
- o_almost_full: registered; reflects occupancies after the current edge's push/pop.
- Error flags: cleared only by rst.
- Counters: increment on handshake; o_pkt_count increments only when o_axis_tlast=1 at the handshake.

Test Plan:
- All 16 lanes push values 0..15 with tlast=0 in one cycle, tready=1 → next cycle tvalid=1, lane i data=i, handshake; o_beat_count=1, FIFOs empty after.
- Lanes 0-7 push in cycle 0, lanes 8-15 in cycle 3 → tvalid low through cycle 3, high in cycle 4 with the correct aligned phit.
- tready=0, all lanes push 24 elements → o_almost_full=1 after the 24th push. Continue to 33 pushes → o_err_overflow=1, the 33rd element dropped. Then tready=1 → exactly 32 phits emitted in order.
- 4-beat packet with tlast on beat 4 in all lanes, tready toggling every cycle → 4 handshakes, tlast only on the 4th, data stable while stalled, o_pkt_count=1.
- Lane 5 tlast=1 while others 0 → o_err_tlast_mismatch=1 at that pop, o_axis_tlast=0.
- 10 elements buffered, assert rst for 1 cycle → tvalid=0, counters and errors 0; a fresh full push produces a correct phit.
